// File: rtl/des_ahb_slave_if.sv
// ---------------------------------------------------------------------------
// des_ahb_slave_if
//
// AHB-Lite slave front end for the Triple-DES core. A bus master programs
// the mode and three 64-bit keys, writes 64-bit data chunks that are handed
// to the core, and drains completed chunks from a result FIFO by reading.
//
// Register map (HADDR[12:10]; HADDR[31:13] must be zero, HADDR[9:0] ignored):
//   0 CTRL/RESULT  write: enc_dec <= HWDATA[0]; read: pop FIFO head
//   1 KEY1         read/write
//   2 KEY2         read/write
//   3 KEY3         read/write
//   4 DATA         write only (reads return 0)
//   5 STATUS       read only: [0] empty, [1] full, [7:4] count,
//                  [8] core_valid, [9] underflow (cleared by this read)
//   6,7            unmapped
//
// Optional feature, macro DES_AHB_ERR_RESP_EN:
//   defined   - unmapped accesses, STATUS writes and DATA reads get a
//               two-cycle ERROR response and change no state.
//   undefined - such accesses complete OKAY; writes are dropped and reads
//               return 0.
//
// Ports:
//   HCLK, HRESET          clock, synchronous active-high reset
//   HTRANS, HWRITE, HADDR address-phase controls
//   HSIZE                 transfer size (not used by the decode)
//   HWDATA                write data (data phase)
//   HRDATA                read data (data phase, combinational)
//   HREADYOUT, HRESP      transfer completion / response
//   enc_dec, key1..key3   mode and keys to the core
//   core_data/valid/ready chunk handshake towards the core
//   res_data/valid/ready  result handshake from the core into the FIFO
//
// Handshake semantics (both core_* and res_* channels): a transfer happens
// on a rising HCLK edge where valid and ready are both high. The source
// keeps valid and data stable until that edge. ready never depends on
// valid from the same channel.
// ---------------------------------------------------------------------------
module des_ahb_slave_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HSIZE,
  input  logic [63:0] HWDATA,
  output logic [63:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        enc_dec,
  output logic [63:0] key1,
  output logic [63:0] key2,
  output logic [63:0] key3,
  output logic [63:0] core_data,
  output logic        core_valid,
  input  logic        core_ready,
  input  logic [63:0] res_data,
  input  logic        res_valid,
  output logic        res_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [2:0] SEL_CTRL   = 3'd0;
  localparam logic [2:0] SEL_KEY1   = 3'd1;
  localparam logic [2:0] SEL_KEY2   = 3'd2;
  localparam logic [2:0] SEL_KEY3   = 3'd3;
  localparam logic [2:0] SEL_DATA   = 3'd4;
  localparam logic [2:0] SEL_STATUS = 3'd5;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // -------------------------------------------------------------------------
  // Data-phase registers: captured from the address phase
  // -------------------------------------------------------------------------
  logic       dpValid;
  logic       dpWrite;
  logic       dpMapped;
  logic [2:0] dpSel;

  logic       addrMapped;
  assign addrMapped = (HADDR[31:13] == 19'd0) && (HADDR[12:10] <= SEL_STATUS);

  // The bus only moves to a new data phase when the current one completes
  // (HREADYOUT = 1); during a wait state the captured phase is held.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dpValid  <= 1'b0;
      dpWrite  <= 1'b0;
      dpMapped <= 1'b0;
      dpSel    <= 3'd0;
    end else if (HREADYOUT) begin
      dpValid <= HTRANS[1];
      if (HTRANS[1]) begin
        dpWrite  <= HWRITE;
        dpMapped <= addrMapped;
        dpSel    <= HADDR[12:10];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Result FIFO state
  // -------------------------------------------------------------------------
  logic [63:0]      fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             fifoEmpty;
  logic             fifoFull;
  logic             push;
  logic             pop;

  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == CNT_FULL);
  assign res_ready = !fifoFull;
  assign push      = res_valid && res_ready;

  // -------------------------------------------------------------------------
  // Data-phase decode and transfer completion
  // -------------------------------------------------------------------------
  logic dataWrPhase;
  logic coreFree;
  logic dataStall;
  logic phaseDone;
  logic wrEn;
  logic rdEn;
  logic underflow;

  assign dataWrPhase = dpValid && dpWrite && dpMapped && (dpSel == SEL_DATA);
  // The holding register is free if empty, or if the core takes its
  // contents on this very edge.
  assign coreFree    = !core_valid || core_ready;
  assign dataStall   = dataWrPhase && !coreFree;

`ifdef DES_AHB_ERR_RESP_EN
  logic badAccess;
  logic errFirst;
  logic errSecond;

  assign badAccess = dpValid && (!dpMapped ||
                                 ( dpWrite && (dpSel == SEL_STATUS)) ||
                                 (!dpWrite && (dpSel == SEL_DATA)));
  // First ERROR cycle stretches the data phase; the second completes it.
  assign errFirst  = badAccess && !errSecond;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      errSecond <= 1'b0;
    end else begin
      errSecond <= errFirst;
    end
  end

  assign HREADYOUT = !(dataStall || errFirst);
  assign HRESP     = badAccess;
`else
  assign HREADYOUT = !dataStall;
  assign HRESP     = 1'b0;
`endif

  // Register side effects happen only on the edge that ends the data phase.
  // Bad accesses never match a write or read target below, so they leave
  // all state untouched in either build.
  assign phaseDone = dpValid && HREADYOUT;
  assign wrEn      = phaseDone &&  dpWrite && dpMapped;
  assign rdEn      = phaseDone && !dpWrite && dpMapped;
  assign pop       = rdEn && (dpSel == SEL_CTRL) && !fifoEmpty;

  // -------------------------------------------------------------------------
  // Control and key registers
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      enc_dec <= 1'b0;
      key1    <= '0;
      key2    <= '0;
      key3    <= '0;
    end else if (wrEn) begin
      case (dpSel)
        SEL_CTRL: enc_dec <= HWDATA[0];
        SEL_KEY1: key1    <= HWDATA;
        SEL_KEY2: key2    <= HWDATA;
        SEL_KEY3: key3    <= HWDATA;
        default:  ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Chunk holding register towards the core
  // -------------------------------------------------------------------------
  logic loadCore;
  assign loadCore = wrEn && (dpSel == SEL_DATA);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      core_data  <= '0;
      core_valid <= 1'b0;
    end else if (loadCore) begin
      // A reload on the same edge the core consumes keeps valid high.
      core_data  <= HWDATA;
      core_valid <= 1'b1;
    end else if (core_valid && core_ready) begin
      core_valid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky underflow flag
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      underflow <= 1'b0;
    end else if (rdEn && (dpSel == SEL_CTRL) && fifoEmpty) begin
      underflow <= 1'b1;
    end else if (rdEn && (dpSel == SEL_STATUS)) begin
      underflow <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Result FIFO
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (push) begin
      fifoMem[wrPtr] <= res_data;
    end
  end

  // FIFO_DEPTH is a power of two, so the pointers wrap by overflowing.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read data
  // -------------------------------------------------------------------------
  logic [3:0]  cntField;
  logic [63:0] statusWord;

  // STATUS has a 4-bit count field regardless of CNT_W.
  generate
    if (CNT_W >= 4) begin : gCntTrunc
      assign cntField = count[3:0];
    end else begin : gCntExt
      assign cntField = {{(4-CNT_W){1'b0}}, count};
    end
  endgenerate

  always_comb begin
    statusWord      = '0;
    statusWord[0]   = fifoEmpty;
    statusWord[1]   = fifoFull;
    statusWord[7:4] = cntField;
    statusWord[8]   = core_valid;
    statusWord[9]   = underflow;
  end

  always_comb begin
    HRDATA = '0;
    if (dpValid && !dpWrite && dpMapped) begin
      case (dpSel)
        SEL_CTRL:   HRDATA = fifoEmpty ? 64'd0 : fifoMem[rdPtr];
        SEL_KEY1:   HRDATA = key1;
        SEL_KEY2:   HRDATA = key2;
        SEL_KEY3:   HRDATA = key3;
        SEL_STATUS: HRDATA = statusWord;
        default:    HRDATA = '0;
      endcase
    end
  end

  // Transfer size and the low address bits carry no meaning for this block.
  logic unusedInputs;
  assign unusedInputs = ^{HSIZE, HADDR[9:0]};

endmodule
